// File: rtl/vram_write_buffer_if.sv
// Avalon-MM slave-side bus bundle for the VRAM posted-write buffer.
// The host drives the master modport and the buffer sits on the slave modport.
interface vram_write_buffer_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic              write;
  logic              read;
  logic              chipselect;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, writedata, write, read, chipselect,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, writedata, write, read, chipselect,
    output waitrequest, readdata
  );
endinterface

// File: rtl/vram_write_buffer.sv
// Posted-write FIFO: absorbs host writes at bus rate and replays them to the
// VRAM address decoder one per cycle while drain_en permits.
module vram_write_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  vram_write_buffer_if.slave bus,
  input  logic               drain_en,
  output logic [ADDR_W-1:0]  dec_addr,
  output logic [DATA_W-1:0]  dec_write_data,
  output logic               dec_chip_select
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] addr_mem_r [DEPTH];
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [ADDR_W-1:0] dec_addr_r;
  logic [DATA_W-1:0] dec_data_r;
  logic              dec_cs_r;
  logic [DATA_W-1:0] readdata_r;

  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;
  logic status_rd_s;

  // Handshake decode; a push is refused while full even if a pop frees a slot
  always_comb begin
    full_s      = (count_r == FULL_CNT);
    empty_s     = (count_r == {CNT_W{1'b0}});
    push_s      = bus.chipselect & bus.write & ~full_s;
    pop_s       = ~empty_s & drain_en;
    status_rd_s = bus.chipselect & bus.read & ~bus.write;
  end

  assign bus.waitrequest = full_s;
  assign bus.readdata    = readdata_r;
  assign dec_addr        = dec_addr_r;
  assign dec_write_data  = dec_data_r;
  assign dec_chip_select = dec_cs_r;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem_r[wr_ptr_r] <= bus.address;
      data_mem_r[wr_ptr_r] <= bus.writedata;
    end
  end

  // Decoder outputs are zeroed on every non-pop cycle so no stale address lingers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_addr_r <= {ADDR_W{1'b0}};
      dec_data_r <= {DATA_W{1'b0}};
      dec_cs_r   <= 1'b0;
    end else if (pop_s) begin
      dec_addr_r <= addr_mem_r[rd_ptr_r];
      dec_data_r <= data_mem_r[rd_ptr_r];
      dec_cs_r   <= 1'b1;
    end else begin
      dec_addr_r <= {ADDR_W{1'b0}};
      dec_data_r <= {DATA_W{1'b0}};
      dec_cs_r   <= 1'b0;
    end
  end

  // Status word: fill level captured at the read cycle, held until the next read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_r <= {DATA_W{1'b0}};
    end else if (status_rd_s) begin
      readdata_r <= DATA_W'(count_r);
    end else begin
      readdata_r <= readdata_r;
    end
  end
endmodule
